// File: rtl/spi_pkg.sv
// Shared types, idle levels and round-robin helper for the SPI master arbiter.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_t;

  localparam logic SPI_IDLE_NSS  = 1'b1;
  localparam logic SPI_IDLE_SCLK = 1'b0;

  // Requester vectors are carried at the maximum supported width.
  localparam int unsigned RR_MAX   = 4;
  localparam int unsigned RR_PTR_W = 2;

  // One-hot winner: first set req bit scanning upward from ptr, modulo n.
  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0]   req,
    input logic [RR_PTR_W-1:0] ptr,
    input int unsigned         n = RR_MAX
  );
    logic [RR_MAX-1:0] win;
    int unsigned       idx;
    win = '0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      idx = (32'(ptr) + i) % n;
      if ((i < n) && (win == '0) && req[RR_PTR_W'(idx)]) begin
        win[RR_PTR_W'(idx)] = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// SPI bus pins shared between the master controller and a slave device.
interface spi_master_arbiter_if;
  logic sclk;
  logic mosi;
  logic nss;
  logic miso;

  modport master (output sclk, output mosi, output nss, input miso);
  modport slave  (input sclk, input mosi, input nss, output miso);
endinterface

// File: rtl/spi_shift_engine.sv
// Mode-0 shift engine: clock divider, sclk generation, bit counter and
// tx/rx shift registers. Loaded by start, shifts while run is high.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic              run,
  input  logic              sample_bit,
  input  logic [DATA_W-1:0] tx_word,
  output logic              tick_c,
  output logic              shift_done_c,
  output logic              sclk,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_word
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sr;

  assign tick_c       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign shift_done_c = run && tick_c && sclk && (bit_cnt == CNT_W'(DATA_W - 1));

  // Divider: counts CLK_DIV-cycle slots while a transfer is in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (!en || tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Shifter: sample on sclk rise, present the next bit on sclk fall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk    <= SPI_IDLE_SCLK;
      mosi    <= 1'b0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_word <= '0;
    end else if (start) begin
      sclk    <= SPI_IDLE_SCLK;
      mosi    <= tx_word[DATA_W-1];
      bit_cnt <= '0;
      tx_sr   <= tx_word;
      rx_word <= '0;
    end else if (run && tick_c) begin
      if (!sclk) begin
        sclk    <= 1'b1;
        rx_word <= {rx_word[DATA_W-2:0], sample_bit};
      end else begin
        sclk    <= 1'b0;
        tx_sr   <= tx_sr << 1;
        mosi    <= tx_sr[DATA_W-2];
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin SPI master shared by NUM_REQ requesters, mode 0, MSB first.
// Optional build macro SPI_ARB_LOOPBACK_EN adds a loopback input that feeds
// the transmitted bit back into the receive shifter instead of miso.
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] tx_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
`ifdef SPI_ARB_LOOPBACK_EN
  input  logic                      loopback,
`endif
  spi_master_arbiter_if.master      spi
);

  localparam int unsigned PTR_W = RR_PTR_W;

  spi_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d, win_q, win_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d, ptr_next_c;
  logic                busy_q, busy_d, nss_q, nss_d;
  logic [DATA_W-1:0]   rx_q, rx_d, tx_sel_c, rx_word;
  logic [RR_MAX-1:0]   pick_full_c;
  logic [NUM_REQ-1:0]  pick_c;
  logic                unused_pick_c;
  logic                start_c, tick_c, shift_done_c, sample_bit_c;
  logic                sclk_w, mosi_w;

  // Winner, its transmit word and the pointer position after it.
  always_comb begin
    pick_full_c = rr_pick(RR_MAX'(req), ptr_q, NUM_REQ);
    pick_c      = pick_full_c[NUM_REQ-1:0];
    ptr_next_c  = ptr_q;
    tx_sel_c    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_c[i]) begin
        ptr_next_c = PTR_W'((i + 1) % NUM_REQ);
        tx_sel_c   = tx_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign unused_pick_c = ^pick_full_c;

`ifdef SPI_ARB_LOOPBACK_EN
  assign sample_bit_c = loopback ? mosi_w : spi.miso;
`else
  assign sample_bit_c = spi.miso;
`endif

  spi_shift_engine #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clock        (clock),
    .reset        (reset),
    .en           (state_q != IDLE),
    .start        (start_c),
    .run          (state_q == SHIFT),
    .sample_bit   (sample_bit_c),
    .tx_word      (tx_sel_c),
    .tick_c       (tick_c),
    .shift_done_c (shift_done_c),
    .sclk         (sclk_w),
    .mosi         (mosi_w),
    .rx_word      (rx_word)
  );

  // Transfer sequencing: next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    win_d   = win_q;
    busy_d  = busy_q;
    nss_d   = nss_q;
    rx_d    = rx_q;
    ptr_d   = ptr_q;
    start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SETUP;
          gnt_d   = pick_c;
          win_d   = pick_c;
          busy_d  = 1'b1;
          nss_d   = 1'b0;
          ptr_d   = ptr_next_c;
          start_c = 1'b1;
        end
      end
      SETUP: begin
        if (tick_c) state_d = SHIFT;
      end
      SHIFT: begin
        if (shift_done_c) state_d = HOLD;
      end
      HOLD: begin
        if (tick_c) begin
          state_d = GAP;
          nss_d   = SPI_IDLE_NSS;
          gnt_d   = '0;
          done_d  = win_q;
          rx_d    = rx_word;
        end
      end
      GAP: begin
        if (tick_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      win_q   <= '0;
      busy_q  <= 1'b0;
      nss_q   <= SPI_IDLE_NSS;
      rx_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
      nss_q   <= nss_d;
      rx_q    <= rx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rx_data  = rx_q;
  assign busy     = busy_q;
  assign spi.nss  = nss_q;
  assign spi.sclk = sclk_w;
  assign spi.mosi = mosi_w;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: vector table plus corner sequences.
module tb_spi_master_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Default instance: 2 requesters, 8 bits, CLK_DIV=2.
  logic [1:0]  req;
  logic [15:0] tx_data;
  logic [1:0]  gnt, done;
  logic [7:0]  rx_data;
  logic        busy;
  spi_master_arbiter_if spi0();

  // Wide/fast instance: 2 requesters, 16 bits, CLK_DIV=1.
  logic [1:0]  req16;
  logic [31:0] tx16;
  logic [1:0]  gnt16, done16;
  logic [15:0] rx16;
  logic        busy16;
  spi_master_arbiter_if spi1();

`ifdef SPI_ARB_LOOPBACK_EN
  logic loopback;
  logic loopback16;
`endif

  spi_master_arbiter #(.NUM_REQ(2), .DATA_W(8), .CLK_DIV(2)) dut (
    .clock(clock), .reset(reset), .req(req), .tx_data(tx_data),
    .gnt(gnt), .done(done), .rx_data(rx_data), .busy(busy),
`ifdef SPI_ARB_LOOPBACK_EN
    .loopback(loopback),
`endif
    .spi(spi0)
  );

  spi_master_arbiter #(.NUM_REQ(2), .DATA_W(16), .CLK_DIV(1)) dut16 (
    .clock(clock), .reset(reset), .req(req16), .tx_data(tx16),
    .gnt(gnt16), .done(done16), .rx_data(rx16), .busy(busy16),
`ifdef SPI_ARB_LOOPBACK_EN
    .loopback(loopback16),
`endif
    .spi(spi1)
  );

  // Slave models: load on nss fall, capture mosi on sclk rise, shift on fall.
  logic [31:0] s0_word = '0, s0_sr = '0, s0_got = '0;
  int          s0_rises = 0;
  logic        s0_psclk = 1'b0, s0_pnss = 1'b1;
  always begin
    @(negedge clock);
    if (s0_pnss && !spi0.nss) begin
      s0_sr = s0_word; s0_got = '0; s0_rises = 0;
    end else if (!spi0.nss) begin
      if (!s0_psclk && spi0.sclk) begin
        s0_got = {s0_got[30:0], spi0.mosi}; s0_rises++;
      end else if (s0_psclk && !spi0.sclk) begin
        s0_sr = s0_sr << 1;
      end
    end
    spi0.miso = s0_sr[7];
    s0_psclk = spi0.sclk; s0_pnss = spi0.nss;
  end

  logic [31:0] s1_word = '0, s1_sr = '0, s1_got = '0;
  logic        s1_psclk = 1'b0, s1_pnss = 1'b1;
  always begin
    @(negedge clock);
    if (s1_pnss && !spi1.nss) begin
      s1_sr = s1_word; s1_got = '0;
    end else if (!spi1.nss) begin
      if (!s1_psclk && spi1.sclk) s1_got = {s1_got[30:0], spi1.mosi};
      else if (s1_psclk && !spi1.sclk) s1_sr = s1_sr << 1;
    end
    spi1.miso = s1_sr[15];
    s1_psclk = spi1.sclk; s1_pnss = spi1.nss;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
  endtask

  task automatic wait_gnt(output int t);
    int n = 0;
    while (gnt == 2'b00 && n < 200) begin step(); n++; end
    check("gnt_seen", 32'(|gnt), 32'd1);
    t = cyc;
  endtask

  task automatic wait_done(output int t);
    int n = 0;
    while (done == 2'b00 && n < 200) begin step(); n++; end
    check("done_seen", 32'(|done), 32'd1);
    t = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin step(); n++; end
    check("busy_clear", 32'(busy), 32'd0);
    step();
  endtask

  typedef struct {
    logic [1:0] req;
    logic [7:0] tx0;
    logic [7:0] tx1;
    logic [7:0] slave;
    logic [1:0] exp_gnt;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  int g, d, prev_g, hi, dcnt, n;
  logic [1:0] exp_g;

  initial begin
    // Pointer starts at 0 after reset; each grant moves it past the winner.
    vecs[0] = '{2'b01, 8'hA5, 8'h00, 8'h3C, 2'b01, 8'hA5, 8'h3C};
    vecs[1] = '{2'b11, 8'h11, 8'h22, 8'hC3, 2'b10, 8'h22, 8'hC3};
    vecs[2] = '{2'b10, 8'h00, 8'hFF, 8'h00, 2'b10, 8'hFF, 8'h00};
    vecs[3] = '{2'b11, 8'h80, 8'h7E, 8'h01, 2'b01, 8'h80, 8'h01};
    vecs[4] = '{2'b01, 8'h00, 8'h99, 8'hFF, 2'b01, 8'h00, 8'hFF};
    vecs[5] = '{2'b10, 8'h66, 8'h3C, 8'hA5, 2'b10, 8'h3C, 8'hA5};

    req = '0; tx_data = '0; req16 = '0; tx16 = '0;
`ifdef SPI_ARB_LOOPBACK_EN
    loopback = 1'b0; loopback16 = 1'b0;
`endif
    repeat (3) step();
    check("reset_state", {16'(0), gnt, done, busy, rx_data, spi0.sclk, spi0.mosi, spi0.nss},
          {16'(0), 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});

    // Contention: both requesting out of reset, grants alternate 0,1,0,1.
    req = 2'b11; tx_data = {8'h22, 8'h11}; s0_word = 32'h5A;
    step();
    reset = 1'b1;
    prev_g = 0;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_gnt(g);
      check("cont_gnt", 32'(gnt), 32'(exp_g));
      if (k > 0) check("cont_spacing", 32'(g - prev_g), 32'd39);
      prev_g = g;
      wait_done(d);
      check("cont_latency", 32'(d - g), 32'd36);
      check("cont_done", 32'(done), 32'(exp_g));
      check("cont_mosi", s0_got, (k % 2 == 0) ? 32'h11 : 32'h22);
      if (k == 3) req = 2'b00;
      hi = 0; dcnt = 0; n = 0;
      while (gnt == 2'b00 && busy && n < 100) begin
        if (spi0.nss) hi++;
        if (done != 2'b00) dcnt++;
        step(); n++;
      end
      check("cont_done_width", 32'(dcnt), 32'd1);
      if (k < 3) check("cont_nss_gap_ge2", 32'(hi >= 2), 32'd1);
    end
    wait_idle();

    // Vector table.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req = vecs[i].req;
      tx_data = {vecs[i].tx1, vecs[i].tx0};
      s0_word = 32'(vecs[i].slave);
      wait_gnt(g);
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      wait_done(d);
      check($sformatf("v%0d_latency", i), 32'(d - g), 32'd36);
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_gnt));
      check($sformatf("v%0d_rx", i), 32'(rx_data), 32'(vecs[i].exp_rx));
      check($sformatf("v%0d_mosi", i), s0_got, 32'(vecs[i].exp_mosi));
      req = 2'b00;
      wait_idle();
    end

    // Mid-transfer reset: abort, idle levels at once, pointer back to 0.
    do_reset();
    req = 2'b01; tx_data = {8'h00, 8'hA5}; s0_word = 32'h3C;
    wait_gnt(g); wait_done(d); req = 2'b00; wait_idle();
    req = 2'b01;
    wait_gnt(g);
    n = 0;
    while (s0_rises < 4 && n < 100) begin step(); n++; end
    check("mid_rises", 32'(s0_rises), 32'd4);
    reset = 1'b0;
    #1;
    check("mid_pins", {29'(0), spi0.nss, spi0.sclk, spi0.mosi}, 32'b100);
    check("mid_gnt_busy", {29'(0), gnt, busy}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done != 2'b00) dcnt++;
    end
    check("mid_no_done", 32'(dcnt), 32'd0);
    req = 2'b11;
    reset = 1'b1;
    wait_gnt(g);
    check("mid_next_gnt", 32'(gnt), 32'b01);
    wait_done(d); req = 2'b00; wait_idle();

    // Inputs changed mid-shift are ignored.
    do_reset();
    req = 2'b01; tx_data = {8'h00, 8'hA5}; s0_word = 32'h3C;
    wait_gnt(g);
    n = 0;
    while (s0_rises < 2 && n < 100) begin step(); n++; end
    tx_data = {8'h00, 8'h5A}; req = 2'b00;
    wait_done(d);
    check("stab_done", 32'(done), 32'b01);
    check("stab_mosi", s0_got, 32'hA5);
    check("stab_rx", 32'(rx_data), 32'h3C);
    repeat (10) step();
    check("stab_idle", {30'(0), busy, |gnt}, 32'd0);

    // CLK_DIV=1, DATA_W=16.
    req16 = 2'b01; tx16 = {16'h0000, 16'hBEEF}; s1_word = 32'h1234;
    n = 0;
    while (gnt16 == 2'b00 && n < 200) begin step(); n++; end
    check("w16_gnt", 32'(gnt16), 32'b01);
    g = cyc;
    n = 0;
    while (done16 == 2'b00 && n < 200) begin step(); n++; end
    d = cyc;
    check("w16_done", 32'(done16), 32'b01);
    check("w16_latency", 32'(d - g), 32'd34);
    check("w16_rx", 32'(rx16), 32'h1234);
    check("w16_mosi", s1_got, 32'hBEEF);
    req16 = 2'b00;
    repeat (5) step();

`ifdef SPI_ARB_LOOPBACK_EN
    // Loopback: rx follows the transmitted word with miso held low.
    do_reset();
    loopback = 1'b1; s0_word = 32'h0;
    req = 2'b01; tx_data = {8'h00, 8'h5A};
    wait_gnt(g); wait_done(d);
    check("lb_rx", 32'(rx_data), 32'h5A);
    req = 2'b00; wait_idle();
    loopback = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
